// File: rtl/johnson_counter_gen.sv
// johnson_counter_gen
// Parametrised W-bit Johnson (twisted-ring) counter with a 2W-state cycle.
// Supports count enable, up/down stepping, synchronous phase load, a binary
// phase index decoded from the ring and a registered wrap pulse.
// Optional feature macro: JOHNSON_SELF_CORRECT_EN
//   defined   -> illegal ring codes are flagged and cleared to phase 0
//   undefined -> illegal is tied low and the ring shifts without recovery

module johnson_counter_gen #(
   parameter int W  = 8,
   parameter int PW = $clog2(2*W)
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          en,
   input  logic          dir,
   input  logic          ld,
   input  logic [PW-1:0] ld_phase,
   output logic [W-1:0]  q,
   output logic [PW-1:0] phase,
   output logic          wrap,
   output logic          illegal
);

   localparam logic [PW-1:0] LastPhase = PW'(2*W-1);

   logic [W-1:0]  ring_q;
   logic [W-1:0]  ring_d;
   logic          wrap_q;
   logic          wrap_d;
   logic [PW-1:0] phaseDec;
   logic          legal;
   logic [W-1:0]  ldCode;
   logic [W-1:0]  upStep;
   logic [W-1:0]  downStep;

   // Ring code for phase p: p<=W means the top p bits are set; beyond W the
   // top (p-W) bits are clear and everything below them is set.
   function automatic logic [W-1:0] codeOf(input int p);
      logic [W-1:0] c;
      c = '0;
      for (int i = 0; i < W; i++) begin
         if (p <= W) c[i] = (i >= W - p);
         else        c[i] = (i < 2*W - p);
      end
      return c;
   endfunction

   // Decode the ring into its phase index; no match leaves phase at 0 and
   // marks the ring as not holding a legal Johnson code.
   always_comb begin
      phaseDec = '0;
      legal    = 1'b0;
      for (int p = 0; p < 2*W; p++) begin
         if (ring_q == codeOf(p)) begin
            phaseDec = PW'(p);
            legal    = 1'b1;
         end
      end
   end

   // Load target and the two shift directions; out-of-range phases load 0.
   always_comb begin
      if (int'(ld_phase) >= 2*W) ldCode = '0;
      else                       ldCode = codeOf(int'(ld_phase));
      upStep   = {~ring_q[0], ring_q[W-1:1]};
      downStep = {ring_q[W-2:0], ~ring_q[W-1]};
   end

   // Next-state selection: load beats correction beats stepping beats hold.
   // Only a real step across the 2W-1/0 boundary raises wrap.
   always_comb begin
      ring_d = ring_q;
      wrap_d = 1'b0;
      if (ld) begin
         ring_d = ldCode;
      end
`ifdef JOHNSON_SELF_CORRECT_EN
      else if (!legal) begin
         ring_d = '0;
      end
`endif
      else if (en) begin
         if (dir) begin
            ring_d = upStep;
            wrap_d = legal && (phaseDec == LastPhase);
         end else begin
            ring_d = downStep;
            wrap_d = legal && (phaseDec == '0);
         end
      end
   end

   // Ring and wrap registers, cleared asynchronously by clr_n.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         ring_q <= '0;
         wrap_q <= 1'b0;
      end else begin
         ring_q <= ring_d;
         wrap_q <= wrap_d;
      end
   end

   assign q     = ring_q;
   assign phase = phaseDec;
   assign wrap  = wrap_q;

`ifdef JOHNSON_SELF_CORRECT_EN
   assign illegal = ~legal;
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_johnson_counter_gen.sv
// tb_johnson_counter_gen
// Drives a W=8 and a W=5 johnson_counter_gen from shared controls and checks
// both against a phase-arithmetic model every cycle, plus literal checkpoints.
// Honours JOHNSON_SELF_CORRECT_EN the same way the design does.

module tb_johnson_counter_gen;

`ifdef JOHNSON_SELF_CORRECT_EN
   localparam bit SC = 1'b1;
`else
   localparam bit SC = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       clr_n;
   logic       en;
   logic       dir;
   logic       ld;
   logic [3:0] ldp8;
   logic [3:0] ldp5;
   logic [7:0] q8;
   logic [3:0] ph8;
   logic       wrap8;
   logic       ill8;
   logic [4:0] q5;
   logic [3:0] ph5;
   logic       wrap5;
   logic       ill5;

   int compared   = 0;
   int mismatched = 0;
   bit checkEn    = 1'b0;

   int          widths [2] = '{8, 5};
   int          mp     [2];
   bit          mIll   [2];
   logic [31:0] mRaw   [2];
   bit          mWrap  [2];

   logic [7:0] upSeq [16] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
                              8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};

   johnson_counter_gen #(.W(8)) dut8 (
      .clk(clk), .clr_n(clr_n), .en(en), .dir(dir), .ld(ld), .ld_phase(ldp8),
      .q(q8), .phase(ph8), .wrap(wrap8), .illegal(ill8)
   );

   johnson_counter_gen #(.W(5)) dut5 (
      .clk(clk), .clr_n(clr_n), .en(en), .dir(dir), .ld(ld), .ld_phase(ldp5),
      .q(q5), .phase(ph5), .wrap(wrap5), .illegal(ill5)
   );

   always #5 clk = ~clk;

   // Johnson code of phase p for width w, from the phase rules directly.
   function automatic logic [31:0] codeOf(input int w, input int p);
      logic [63:0] ones;
      logic [63:0] mask;
      mask = (64'd1 << w) - 64'd1;
      if (p <= w) begin
         ones = ((64'd1 << p) - 64'd1) << (w - p);
         return ones[31:0];
      end
      ones = ((64'd1 << (p - w)) - 64'd1) << (2*w - p);
      ones = ~ones & mask;
      return ones[31:0];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic e, input logic d, input logic l,
                                input logic [3:0] p8, input logic [3:0] p5);
      en   = e;
      dir  = d;
      ld   = l;
      ldp8 = p8;
      ldp5 = p5;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   // One edge of the behavioural model for counter d.
   task automatic modelStep(input int d, input int ldp);
      int          w;
      int          n;
      logic [31:0] mask;
      w    = widths[d];
      n    = 2 * w;
      mask = codeOf(w, w);
      if (ld) begin
         mp[d]    = (ldp >= n) ? 0 : ldp;
         mIll[d]  = 1'b0;
         mWrap[d] = 1'b0;
      end else if (mIll[d] && SC) begin
         mp[d]    = 0;
         mIll[d]  = 1'b0;
         mWrap[d] = 1'b0;
      end else if (en) begin
         mWrap[d] = 1'b0;
         if (mIll[d]) begin
            if (dir) mRaw[d] = ((mRaw[d] >> 1) | ((~mRaw[d] & 32'd1) << (w - 1))) & mask;
            else     mRaw[d] = ((mRaw[d] << 1) | ((~mRaw[d] >> (w - 1)) & 32'd1)) & mask;
         end else if (dir) begin
            mWrap[d] = (mp[d] == n - 1);
            mp[d]    = (mp[d] + 1) % n;
         end else begin
            mWrap[d] = (mp[d] == 0);
            mp[d]    = (mp[d] + n - 1) % n;
         end
      end else begin
         mWrap[d] = 1'b0;
      end
   endtask

   always @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         for (int d = 0; d < 2; d++) begin
            mp[d]    = 0;
            mIll[d]  = 1'b0;
            mRaw[d]  = '0;
            mWrap[d] = 1'b0;
         end
      end else begin
         modelStep(0, int'(ldp8));
         modelStep(1, int'(ldp5));
      end
   end

   task automatic compareDut(input int d, input logic [31:0] aq, input logic [31:0] aph,
                             input logic aw, input logic ai);
      logic [31:0] eq;
      eq = mIll[d] ? mRaw[d] : codeOf(widths[d], mp[d]);
      checkOutput($sformatf("model q W%0d", widths[d]), aq, eq);
      checkOutput($sformatf("model phase W%0d", widths[d]), aph, mIll[d] ? 32'd0 : 32'(mp[d]));
      checkOutput($sformatf("model wrap W%0d", widths[d]), {31'd0, aw}, {31'd0, mWrap[d]});
      checkOutput($sformatf("model illegal W%0d", widths[d]), {31'd0, ai}, {31'd0, mIll[d] & SC});
   endtask

   always @(negedge clk) begin
      if (checkEn) begin
         compareDut(0, {24'd0, q8}, {28'd0, ph8}, wrap8, ill8);
         compareDut(1, {27'd0, q5}, {28'd0, ph5}, wrap5, ill5);
      end
   end

   initial begin
      clr_n = 1'b0;
      en    = 1'b0;
      dir   = 1'b1;
      ld    = 1'b0;
      ldp8  = '0;
      ldp5  = '0;
      #1;
      checkOutput("reset q8", {24'd0, q8}, 32'h00);
      checkOutput("reset phase8", {28'd0, ph8}, 32'd0);
      checkOutput("reset wrap8", {31'd0, wrap8}, 32'd0);
      checkOutput("reset illegal8", {31'd0, ill8}, 32'd0);
      checkOutput("model code W8 p9", codeOf(8, 9), 32'h7F);
      checkOutput("model code W5 p7", codeOf(5, 7), 32'h07);
      @(negedge clk);
      clr_n   = 1'b1;
      #1;
      checkEn = 1'b1;

      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
         checkOutput($sformatf("up q step %0d", i), {24'd0, q8}, {24'd0, upSeq[i]});
         checkOutput($sformatf("up phase step %0d", i), {28'd0, ph8}, 32'((i + 1) % 16));
         checkOutput($sformatf("up wrap step %0d", i), {31'd0, wrap8}, (i == 15) ? 32'd1 : 32'd0);
      end

      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
      checkOutput("down q first", {24'd0, q8}, 32'h01);
      checkOutput("down phase first", {28'd0, ph8}, 32'd15);
      checkOutput("down wrap first", {31'd0, wrap8}, 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
      checkOutput("down q second", {24'd0, q8}, 32'h03);
      checkOutput("down phase second", {28'd0, ph8}, 32'd14);
      checkOutput("down wrap second", {31'd0, wrap8}, 32'd0);

      applyStimulus(1'b1, 1'b1, 1'b1, 4'd9, 4'd12);
      checkOutput("load q8 phase 9", {24'd0, q8}, 32'h7F);
      checkOutput("load phase8 9", {28'd0, ph8}, 32'd9);
      checkOutput("load wrap8", {31'd0, wrap8}, 32'd0);
      checkOutput("load q5 out of range", {27'd0, q5}, 32'h00);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
         checkOutput($sformatf("hold q8 %0d", i), {24'd0, q8}, 32'h7F);
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 4'd15, 4'd7);
      checkOutput("load q8 phase 15", {24'd0, q8}, 32'h01);
      checkOutput("load q5 phase 7", {27'd0, q5}, 32'h07);

      #2;
      force dut8.ring_q = 8'h55;
      mIll[0] = 1'b1;
      mRaw[0] = 32'h55;
      #1;
      checkOutput("forced phase8", {28'd0, ph8}, 32'd0);
      checkOutput("forced illegal8", {31'd0, ill8}, {31'd0, SC});
      release dut8.ring_q;
`ifdef JOHNSON_SELF_CORRECT_EN
      applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      checkOutput("self-correct q8", {24'd0, q8}, 32'h00);
      checkOutput("self-correct illegal8", {31'd0, ill8}, 32'd0);
      checkOutput("self-correct wrap8", {31'd0, wrap8}, 32'd0);
`else
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
      checkOutput("illegal shift q8", {24'd0, q8}, 32'h2A);
      checkOutput("illegal shift flag8", {31'd0, ill8}, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 4'd3, 4'd3);
      checkOutput("recover load q8", {24'd0, q8}, 32'hE0);
`endif

      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            #2;
            clr_n = 1'b0;
            #1;
            checkOutput("async reset q8", {24'd0, q8}, 32'h00);
            checkOutput("async reset wrap8", {31'd0, wrap8}, 32'd0);
            checkOutput("async reset q5", {27'd0, q5}, 32'h00);
            @(negedge clk);
            clr_n = 1'b1;
            #1;
         end
         applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)));
      end

      checkEn = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
